// File: rtl/mincpu_isa_pkg.sv
// Shared RV32I encoding constants: format codes, opcodes, NOP and immediate bounds.
// Also provides the signed range helper used by the immediate packer.
package mincpu_isa_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

  // Stage-1 payload: raw register fields plus the already-scattered immediate.
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_bits;
    logic        err;
  } s1_t;

  function automatic logic imm_in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Scatters a signed immediate into its RV32I instruction bit positions and flags
// out-of-range, misaligned or illegal-format immediates. Purely combinational.
module imm_pack
  import mincpu_isa_pkg::*;
#(
  parameter int CHECK_ALIGN = 1
) (
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits,
  output logic        range_err
);

  logic align_err;
  assign align_err = (CHECK_ALIGN != 0) && imm[0];

  always_comb begin
    imm_bits  = '0;
    range_err = 1'b0;
    case (fmt)
      FMT_R: ;
      FMT_I: begin
        imm_bits  = {imm[11:0], 20'b0};
        range_err = !imm_in_range(imm, IMM_I_MIN, IMM_I_MAX);
      end
      FMT_S: begin
        imm_bits  = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        range_err = !imm_in_range(imm, IMM_I_MIN, IMM_I_MAX);
      end
      FMT_B: begin
        imm_bits  = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        range_err = !imm_in_range(imm, IMM_B_MIN, IMM_B_MAX) || align_err;
      end
      FMT_U: begin
        imm_bits  = {imm[31:12], 12'b0};
        range_err = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        imm_bits  = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        range_err = !imm_in_range(imm, IMM_J_MIN, IMM_J_MAX) || align_err;
      end
      default: range_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage elastic RV32I encoder: stage 1 captures fields and the immediate check,
// stage 2 holds the packed word. Errored words flow through as NOP with out_err set.
module instr_encoder
  import mincpu_isa_pkg::*;
#(
  parameter int COUNT_W     = 16,
  parameter int ERR_W       = 8,
  parameter int CHECK_ALIGN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_fmt,
  input  logic [6:0]         in_opcode,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [2:0]         in_funct3,
  input  logic [6:0]         in_funct7,
  input  logic [31:0]        in_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic               out_err,
  output logic [COUNT_W-1:0] enc_count,
  output logic [ERR_W-1:0]   err_count
);

  logic        s1_valid;
  logic        s2_valid;
  logic        s1_load;
  logic        s2_load;
  logic        handoff;
  s1_t         s1_q;
  logic [31:0] imm_bits;
  logic        imm_err;
  logic [31:0] word;

  imm_pack #(.CHECK_ALIGN(CHECK_ALIGN)) u_imm_pack (
    .fmt      (in_fmt),
    .imm      (in_imm),
    .imm_bits (imm_bits),
    .range_err(imm_err)
  );

  assign in_ready  = !rst && (!s1_valid || !s2_valid || out_ready);
  assign s1_load   = in_valid && in_ready;
  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign out_valid = s2_valid;
  assign handoff   = s2_valid && out_ready;

  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_q <= '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                funct3: in_funct3, funct7: in_funct7, imm_bits: imm_bits, err: imm_err};
    end
  end

  // Register fields go in only where the format defines them; immediate bits are OR'd on top.
  always_comb begin
    word = {25'b0, s1_q.opcode};
    case (s1_q.fmt)
      FMT_R: begin
        word[31:25] = s1_q.funct7;
        word[24:20] = s1_q.rs2;
        word[19:15] = s1_q.rs1;
        word[14:12] = s1_q.funct3;
        word[11:7]  = s1_q.rd;
      end
      FMT_I: begin
        word[19:15] = s1_q.rs1;
        word[14:12] = s1_q.funct3;
        word[11:7]  = s1_q.rd;
      end
      FMT_S, FMT_B: begin
        word[24:20] = s1_q.rs2;
        word[19:15] = s1_q.rs1;
        word[14:12] = s1_q.funct3;
      end
      FMT_U, FMT_J: word[11:7] = s1_q.rd;
      default: ;
    endcase
    word = word | s1_q.imm_bits;
    if (s1_q.err) word = NOP_INSTR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      if (s1_load)      s1_valid <= 1'b1;
      else if (s2_load) s1_valid <= 1'b0;

      if (s2_load) begin
        s2_valid  <= 1'b1;
        out_instr <= word;
        out_err   <= s1_q.err;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end

      if (handoff) begin
        enc_count <= enc_count + COUNT_W'(1);
        if (out_err && (err_count != '1)) err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Streaming RV32I instruction encoder, the inverse of immediate_gen_optimized and the decode path. It accepts decoded fields plus a 32-bit signed immediate and emits the packed 32-bit instruction word. Every immediate is range- and alignment-checked. Used by the self-test/stimulus generator feeding the optimized datapath, and by the boot-ROM patcher. It is a 2-stage elastic pipeline with valid/ready on both sides and statistics counters.

Parameters:
COUNT_W, 16, width of encoded-instruction counter (wraps)
ERR_W, 8, width of error counter (saturates)
CHECK_ALIGN, 1, 1 = B/J immediates must be even; 0 = bit 0 silently dropped

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  input fields valid
in_ready  out  1  encoder can accept this cycle
in_fmt  in  3  format: 0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
in_opcode  in  7  opcode[6:0]
in_rd  in  5  rd
in_rs1  in  5  rs1
in_rs2  in  5  rs2
in_funct3  in  3  funct3
in_funct7  in  7  funct7 (R only)
in_imm  in  32  signed immediate (U: full value with low 12 bits)
out_valid  out  1  encoded word valid
out_ready  in  1  downstream accepts
out_instr  out  32  encoded instruction
out_err  out  1  immediate/format error for this word
enc_count  out  COUNT_W  words handed off (out_valid&&out_ready)
err_count  out  ERR_W  handed-off words with out_err=1

Behaviour:
- Reset: clears s1_valid, s2_valid, out_instr=0, out_err=0, enc_count=0, err_count=0. in_ready=0 while rst is high. in_ready=1 the first cycle after reset.
- Stage 1 registers the fields and the range/alignment check. Stage 2 registers the packed word. Latency is in-handshake to out_valid = 2 cycles. Throughput is 1 word/cycle.
- Advance rules: s2_load = s1_valid && (!s2_valid || out_ready); s1_load = in_valid && in_ready; in_ready = !s1_valid || !s2_valid || out_ready. s1_valid holds if it is not consumed.
- out_instr/out_err are stable while out_valid && !out_ready. No data changes under stall.
- Packing follows standard RV32I bit scatter: I imm[11:0]->[31:20]; S imm[11:5]->[31:25], imm[4:0]->[11:7]; B imm[12|10:5]->[31|30:25], imm[4:1|11]->[11:8|7]; U imm[31:12]->[31:12]; J imm[20|10:1|11|19:12]->[31|30:21|20|19:12]. R ignores in_imm.
- Error conditions:
  - I/S: imm outside [-2048, 2047].
  - B: outside [-4096, 4094] or (CHECK_ALIGN && imm[0]).
  - J: outside [-1048576, 1048574] or (CHECK_ALIGN && imm[0]).
  - U: imm[11:0] != 0.
  - fmt 6/7: always an error.
- On error: out_err=1, out_instr=32'h00000013 (NOP). The word still flows; the pipeline is never stalled by an error.
- Counters update only on out_valid && out_ready. enc_count wraps at 2^COUNT_W. err_count saturates at all-ones.
- Reset mid-operation: in-flight words are discarded and no handshake completes that cycle. Counters are cleared.
- Simultaneous load of s1 and drain of s2 in one cycle is legal and is required for full throughput.

Decomposition:
- Shared package mincpu_isa_pkg holds:
  - format code constants
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR)
  - NOP_INSTR = 32'h00000013
  - immediate bounds per format
- One combinational sub-module, imm_pack (fmt, imm -> 32-bit immediate bit-field mask, range_err), instantiated in stage 1/2. It is unit-testable against immediate_gen_optimized as a round trip.

Test Plan:
- fmt=I, op=0010011, rd=1, rs1=0, f3=0, imm=1 -> out_instr=0x00100093, out_err=0, out_valid exactly 2 cycles after handshake.
- fmt=S, op=0100011, rs1=4, rs2=4, f3=010, imm=4 -> 0x00422223. fmt=B, op=1100011, rs1=1, rs2=2, f3=001, imm=8 -> 0x00209463. Feeding both words to immediate_gen_optimized returns 4 and 8.
- Error path:
  - fmt=I, imm=2048 -> out_instr=0x00000013, out_err=1.
  - fmt=B, imm=7 -> err.
  - fmt=U, imm=0x12345001 -> err.
  - fmt=7 -> err.
  - After all of the above, err_count=4.
- Back-to-back stream of 10 words with out_ready=1 -> 10 outputs on consecutive cycles, enc_count=10. Then hold out_ready=0 for 5 cycles -> in_ready drops after 2 accepted words, out_instr is stable, and no word is lost or duplicated on release.
- Assert rst with both stages full -> next cycle out_valid=0, counters=0, and in_ready=0 during reset / 1 after. Preload err_count=255 via 255 error words, then one more error -> stays 255.
